// File: rtl/timeout_sched_pkg.sv
// Shared state encoding and index-width helper for the timeout scheduler
// and any other scheduler that reuses its round-robin arbiter.
package timeout_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Owner index width; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timeout_sched_rr_arbiter.sv
// Combinational round-robin select: first asserted req searching from
// pointer+1 with wrap-around. Returns one-hot sel, its index and an any flag.
module rr_arbiter
  import timeout_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  sel,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW-1:0] cand;

  // The pointer's own slot is visited last, so the previous owner yields to others.
  always_comb begin
    sel   = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(pointer) + k) % N);
      if (!any && req[cand]) begin
        sel[cand] = 1'b1;
        index     = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timeout_sched.sv
// One countdown timer shared round-robin among N requesters.
// Define TIMEOUT_SCHED_CANCEL_EN to abort a running timeout when its owner drops req.
module timeout_sched
  import timeout_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] value,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   expired,
  output logic           busy,
  output logic [W-1:0]   remain
);

  localparam int IW = idx_width(N);

  state_t        state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [IW-1:0] pointer, pointer_nx;
  logic [N-1:0]  grant_nx, expired_nx;
  logic [W-1:0]  remain_nx;

  logic [N-1:0]  arb_sel;
  logic [IW-1:0] arb_index;
  logic          arb_any;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (req),
    .pointer (pointer),
    .sel     (arb_sel),
    .index   (arb_index),
    .any     (arb_any)
  );

  // All outputs are registered; busy is derived from the next state so it tracks state exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= '0;
      pointer <= IW'(N - 1);
      grant   <= '0;
      expired <= '0;
      remain  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      pointer <= pointer_nx;
      grant   <= grant_nx;
      expired <= expired_nx;
      remain  <= remain_nx;
      busy    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    pointer_nx = pointer;
    grant_nx   = grant;
    expired_nx = '0;
    remain_nx  = remain;
    case (state)
      IDLE: begin
        if (arb_any) begin
          owner_nx   = arb_index;
          pointer_nx = arb_index;
          grant_nx   = arb_sel;
          remain_nx  = value[arb_index*W +: W];
          state_nx   = RUN;
        end
      end
      RUN: begin
`ifdef TIMEOUT_SCHED_CANCEL_EN
        if (!req[owner]) begin
          grant_nx  = '0;
          remain_nx = '0;
          state_nx  = IDLE;
        end else
`endif
        // A loaded value of 0 expires on the first edge, same as 1.
        if (remain <= W'(1)) begin
          grant_nx          = '0;
          remain_nx         = '0;
          expired_nx[owner] = 1'b1;
          state_nx          = DONE;
        end else begin
          remain_nx = remain - W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        grant_nx  = '0;
        remain_nx = '0;
        state_nx  = IDLE;
      end
    endcase
  end

endmodule
